// File: rtl/game_timer_pkg.sv
// Shared types and constants for the game timer: FSM state encoding, BCD digit
// width and the active-low seven-segment code table.
package game_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int BCD_W = 4;

  // Segment order {g,f,e,d,c,b,a}, active low; codes 10..15 blank the display.
  localparam logic [6:0] SEG_CODE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b1111111, 7'b1111111,
    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
  };

endpackage

// File: rtl/game_timer_bcd_digit.sv
// One BCD digit of the counter chain: load (clamped to 9) beats inc/dec; carry
// and borrow are combinational so the whole chain settles within one cycle.
module bcd_digit
  import game_timer_pkg::*;
(
  input  logic             clock,
  input  logic             resetn,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  output logic [BCD_W-1:0] value,
  output logic             carry,
  output logic             borrow
);

  logic [BCD_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load)     value_d = (load_val > 4'd9) ? 4'd9 : load_val;
    else if (inc) value_d = (value_q == 4'd9) ? 4'd0 : value_q + 4'd1;
    else if (dec) value_d = (value_q == 4'd0) ? 4'd9 : value_q - 4'd1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) value_q <= '0;
    else         value_q <= value_d;
  end

  assign value  = value_q;
  assign carry  = inc && !load && (value_q == 4'd9);
  assign borrow = dec && !load && (value_q == 4'd0);

endmodule

// File: rtl/game_timer.sv
// Prescaled BCD game timer with IDLE/RUN/PAUSE/DONE control.
// Optional seven-segment output enabled by defining GAME_TIMER_SEG_EN.
module game_timer
  import game_timer_pkg::*;
#(
  parameter int DIV        = 1666667,
  parameter int NUM_DIGITS = 4,
  parameter int COUNT_DOWN = 0,
  parameter int WRAP       = 1
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        start,
  input  logic                        pause,
  input  logic                        clear,
  input  logic [BCD_W*NUM_DIGITS-1:0] preset,
  output logic [BCD_W*NUM_DIGITS-1:0] digits,
  output logic                        tick,
  output logic                        rollover,
  output logic                        done,
  output logic [1:0]                  state
`ifdef GAME_TIMER_SEG_EN
  ,
  output logic [7*NUM_DIGITS-1:0]     seg
`endif
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  state_e                      state_q, state_d;
  logic [PW-1:0]               presc_q, presc_d;
  logic                        tick_q, tick_d, roll_q, roll_d;
  logic                        load, inc_en, dec_en;
  logic [NUM_DIGITS:0]         inc_chain, dec_chain;
  logic [BCD_W*NUM_DIGITS-1:0] value_bus, load_val;
  logic                        near_full, near_empty, all_nine, all_zero;
  logic                        chain_unused;

  assign load_val     = (COUNT_DOWN != 0) ? preset : '0;
  assign inc_chain[0] = inc_en;
  assign dec_chain[0] = dec_en;
  // Terminal events are decoded from the digit values, not the chain outputs.
  assign chain_unused = inc_chain[NUM_DIGITS] | dec_chain[NUM_DIGITS];

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    bcd_digit u_digit (
      .clock    (clock),
      .resetn   (resetn),
      .inc      (inc_chain[gi]),
      .dec      (dec_chain[gi]),
      .load     (load),
      .load_val (load_val[BCD_W*gi +: BCD_W]),
      .value    (value_bus[BCD_W*gi +: BCD_W]),
      .carry    (inc_chain[gi+1]),
      .borrow   (dec_chain[gi+1])
    );
  end

  always_comb begin
    near_full  = (value_bus[BCD_W-1:0] == 4'd8);
    near_empty = (value_bus[BCD_W-1:0] == 4'd1);
    all_nine   = (value_bus[BCD_W-1:0] == 4'd9);
    all_zero   = (value_bus[BCD_W-1:0] == 4'd0);
    for (int i = 1; i < NUM_DIGITS; i++) begin
      near_full  = near_full  && (value_bus[BCD_W*i +: BCD_W] == 4'd9);
      near_empty = near_empty && (value_bus[BCD_W*i +: BCD_W] == 4'd0);
      all_nine   = all_nine   && (value_bus[BCD_W*i +: BCD_W] == 4'd9);
      all_zero   = all_zero   && (value_bus[BCD_W*i +: BCD_W] == 4'd0);
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    roll_d  = 1'b0;
    load    = 1'b0;
    inc_en  = 1'b0;
    dec_en  = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      presc_d = '0;
      load    = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          load    = 1'b1;
          presc_d = '0;
          if (start) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
            // A tick landing on the pause edge is dropped, not deferred.
            if (presc_q == PRESC_MAX) presc_d = '0;
          end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (COUNT_DOWN != 0) begin
              // A zero preset is already terminal: stop without decrementing.
              dec_en = !all_zero;
              if (all_zero || near_empty) begin
                state_d = ST_DONE;
                roll_d  = (WRAP != 0);
              end
            end else begin
              inc_en = 1'b1;
              if (WRAP != 0)      roll_d  = all_nine;
              else if (near_full) state_d = ST_DONE;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        ST_PAUSE: begin
          if (pause) state_d = ST_RUN;
        end
        ST_DONE: begin
          presc_d = '0;
          if (start) begin
            load    = 1'b1;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      tick_q  <= 1'b0;
      roll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      roll_q  <= roll_d;
    end
  end

  assign digits   = value_bus;
  assign tick     = tick_q;
  assign rollover = roll_q;
  assign done     = (state_q == ST_DONE);
  assign state    = state_q;

`ifdef GAME_TIMER_SEG_EN
  logic [6:0] seg_q [NUM_DIGITS];

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_seg
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) seg_q[gi] <= SEG_CODE[0];
      else         seg_q[gi] <= SEG_CODE[value_bus[BCD_W*gi +: BCD_W]];
    end
    assign seg[7*gi +: 7] = seg_q[gi];
  end
`endif

endmodule

// File: tb/tb_game_timer.sv
// Directed self-checking bench for game_timer: three instances (up/wrap,
// up/saturate, down/wrap) with DIV=4 and two digits share one stimulus stream.
module tb_game_timer;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       start = 1'b0, pause = 1'b0, clear = 1'b0;
  logic [7:0] preset = 8'h03;

  logic [7:0] up_digits, sat_digits, dn_digits;
  logic       up_tick, sat_tick, dn_tick;
  logic       up_roll, sat_roll, dn_roll;
  logic       up_done, sat_done, dn_done;
  logic [1:0] up_state, sat_state, dn_state;
`ifdef GAME_TIMER_SEG_EN
  logic [13:0] up_seg, sat_seg, dn_seg;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  game_timer #(.DIV(4), .NUM_DIGITS(2), .COUNT_DOWN(0), .WRAP(1)) dut_up (
    .clock(clock), .resetn(resetn), .start(start), .pause(pause), .clear(clear),
    .preset(preset), .digits(up_digits), .tick(up_tick), .rollover(up_roll),
    .done(up_done), .state(up_state)
`ifdef GAME_TIMER_SEG_EN
    , .seg(up_seg)
`endif
  );

  game_timer #(.DIV(4), .NUM_DIGITS(2), .COUNT_DOWN(0), .WRAP(0)) dut_sat (
    .clock(clock), .resetn(resetn), .start(start), .pause(pause), .clear(clear),
    .preset(preset), .digits(sat_digits), .tick(sat_tick), .rollover(sat_roll),
    .done(sat_done), .state(sat_state)
`ifdef GAME_TIMER_SEG_EN
    , .seg(sat_seg)
`endif
  );

  game_timer #(.DIV(4), .NUM_DIGITS(2), .COUNT_DOWN(1), .WRAP(1)) dut_dn (
    .clock(clock), .resetn(resetn), .start(start), .pause(pause), .clear(clear),
    .preset(preset), .digits(dn_digits), .tick(dn_tick), .rollover(dn_roll),
    .done(dn_done), .state(dn_state)
`ifdef GAME_TIMER_SEG_EN
    , .seg(dn_seg)
`endif
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; cyc(1); clear = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1; cyc(1); pause = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #2;
    total++; if (up_state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", up_state); else passed++;
    total++; if (up_digits !== 8'h00) $display("FAIL reset_digits: got %h expected 00", up_digits); else passed++;
    total++; if ({up_tick, up_roll, up_done} !== 3'b000) $display("FAIL reset_pulses: got %b expected 000", {up_tick, up_roll, up_done}); else passed++;
    total++; if (dn_digits !== 8'h00) $display("FAIL reset_dn_digits: got %h expected 00", dn_digits); else passed++;
    @(negedge clock); resetn = 1'b1;
    cyc(1);
    $display("reset released: up_state=%0d dn_digits=%h", up_state, dn_digits);
    total++; if (up_state !== 2'd0) $display("FAIL idle_state: got %0d expected 0", up_state); else passed++;
    total++; if (dn_digits !== 8'h03) $display("FAIL idle_preset: got %h expected 03", dn_digits); else passed++;
  endtask

  task automatic test_up_count();
    logic [7:0] exp;
    pulse_clear();
    pulse_start();
    total++; if (up_state !== 2'd1) $display("FAIL start_state: got %0d expected 1", up_state); else passed++;
    total++; if (up_digits !== 8'h00) $display("FAIL start_digits: got %h expected 00", up_digits); else passed++;
    for (int k = 1; k <= 10; k++) begin
      exp = 8'(((k / 10) * 16) + (k % 10));
      cyc(3);
      total++; if (up_tick !== 1'b0) $display("FAIL tick_early_%0d: got %b expected 0", k, up_tick); else passed++;
      cyc(1);
      $display("tick %0d: tick=%b digits=%h", k, up_tick, up_digits);
      total++; if (up_tick !== 1'b1) $display("FAIL tick_%0d: got %b expected 1", k, up_tick); else passed++;
      total++; if (up_digits !== exp) $display("FAIL count_%0d: got %h expected %h", k, up_digits, exp); else passed++;
    end
  endtask

  task automatic test_wrap();
    cyc(4 * 89);
    $display("tick 99: up=%h sat=%h sat_state=%0d", up_digits, sat_digits, sat_state);
    total++; if (up_digits !== 8'h99) $display("FAIL up_99: got %h expected 99", up_digits); else passed++;
    total++; if (up_roll !== 1'b0) $display("FAIL roll_early: got %b expected 0", up_roll); else passed++;
    total++; if (sat_digits !== 8'h99) $display("FAIL sat_99: got %h expected 99", sat_digits); else passed++;
    total++; if (sat_state !== 2'd3) $display("FAIL sat_done_state: got %0d expected 3", sat_state); else passed++;
    total++; if (sat_done !== 1'b1) $display("FAIL sat_done: got %b expected 1", sat_done); else passed++;
    cyc(4);
    $display("wrap: up=%h roll=%b state=%0d", up_digits, up_roll, up_state);
    total++; if (up_digits !== 8'h00) $display("FAIL wrap_digits: got %h expected 00", up_digits); else passed++;
    total++; if (up_roll !== 1'b1) $display("FAIL wrap_roll: got %b expected 1", up_roll); else passed++;
    total++; if (up_state !== 2'd1) $display("FAIL wrap_state: got %0d expected 1", up_state); else passed++;
    total++; if (sat_digits !== 8'h99) $display("FAIL sat_hold: got %h expected 99", sat_digits); else passed++;
    total++; if (sat_tick !== 1'b0) $display("FAIL sat_tick: got %b expected 0", sat_tick); else passed++;
    cyc(1);
    total++; if (up_roll !== 1'b0) $display("FAIL roll_width: got %b expected 0", up_roll); else passed++;
  endtask

  task automatic test_clamp();
    preset = 8'h3C;
    pulse_clear();
    $display("clamp: preset=3C dn_digits=%h", dn_digits);
    total++; if (dn_digits !== 8'h39) $display("FAIL clamp: got %h expected 39", dn_digits); else passed++;
    preset = 8'h03;
    cyc(1);
  endtask

  task automatic test_down();
    pulse_clear();
    pulse_start();
    total++; if (dn_digits !== 8'h03) $display("FAIL dn_load: got %h expected 03", dn_digits); else passed++;
    total++; if (dn_state !== 2'd1) $display("FAIL dn_run: got %0d expected 1", dn_state); else passed++;
    cyc(4);
    total++; if (dn_digits !== 8'h02) $display("FAIL dn_02: got %h expected 02", dn_digits); else passed++;
    cyc(4);
    total++; if (dn_digits !== 8'h01) $display("FAIL dn_01: got %h expected 01", dn_digits); else passed++;
    cyc(4);
    $display("down end: digits=%h state=%0d done=%b roll=%b", dn_digits, dn_state, dn_done, dn_roll);
    total++; if (dn_digits !== 8'h00) $display("FAIL dn_00: got %h expected 00", dn_digits); else passed++;
    total++; if (dn_state !== 2'd3) $display("FAIL dn_done_state: got %0d expected 3", dn_state); else passed++;
    total++; if (dn_done !== 1'b1) $display("FAIL dn_done: got %b expected 1", dn_done); else passed++;
    total++; if (dn_roll !== 1'b1) $display("FAIL dn_roll: got %b expected 1", dn_roll); else passed++;
    cyc(1);
    total++; if (dn_roll !== 1'b0) $display("FAIL dn_roll_width: got %b expected 0", dn_roll); else passed++;
    cyc(5);
    total++; if ({dn_state, dn_digits} !== {2'd3, 8'h00}) $display("FAIL dn_hold: got %0d/%h expected 3/00", dn_state, dn_digits); else passed++;
    pulse_start();
    $display("down restart: digits=%h state=%0d", dn_digits, dn_state);
    total++; if ({dn_state, dn_digits} !== {2'd1, 8'h03}) $display("FAIL dn_reload: got %0d/%h expected 1/03", dn_state, dn_digits); else passed++;
  endtask

  task automatic test_pause();
    pulse_clear();
    pulse_start();
    cyc(2);
    pulse_pause();
    total++; if (up_state !== 2'd2) $display("FAIL pause_state: got %0d expected 2", up_state); else passed++;
    cyc(10);
    total++; if ({up_tick, up_digits} !== {1'b0, 8'h00}) $display("FAIL pause_frozen: got %b/%h expected 0/00", up_tick, up_digits); else passed++;
    pulse_pause();
    total++; if ({up_state, up_tick} !== {2'd1, 1'b0}) $display("FAIL resume: got %0d/%b expected 1/0", up_state, up_tick); else passed++;
    cyc(1);
    total++; if (up_tick !== 1'b0) $display("FAIL resume_tick_early: got %b expected 0", up_tick); else passed++;
    cyc(1);
    $display("resume: tick=%b digits=%h", up_tick, up_digits);
    total++; if ({up_tick, up_digits} !== {1'b1, 8'h01}) $display("FAIL resume_tick: got %b/%h expected 1/01", up_tick, up_digits); else passed++;
    cyc(3);
    pulse_pause();
    $display("pause on tick: tick=%b digits=%h state=%0d", up_tick, up_digits, up_state);
    total++; if ({up_tick, up_digits} !== {1'b0, 8'h01}) $display("FAIL tick_discard: got %b/%h expected 0/01", up_tick, up_digits); else passed++;
    total++; if (up_state !== 2'd2) $display("FAIL discard_state: got %0d expected 2", up_state); else passed++;
  endtask

  task automatic test_clear_priority();
    pulse_clear();
    pulse_start();
    cyc(12);
    total++; if (up_digits !== 8'h03) $display("FAIL pre_clear: got %h expected 03", up_digits); else passed++;
    cyc(3);
    clear = 1'b1; start = 1'b1;
    cyc(1);
    clear = 1'b0; start = 1'b0;
    $display("clear+start+tick: state=%0d digits=%h tick=%b", up_state, up_digits, up_tick);
    total++; if ({up_state, up_digits, up_tick} !== {2'd0, 8'h00, 1'b0}) $display("FAIL clear_prio: got %0d/%h/%b expected 0/00/0", up_state, up_digits, up_tick); else passed++;
    cyc(4);
    total++; if ({up_state, up_tick} !== {2'd0, 1'b0}) $display("FAIL clear_stay: got %0d/%b expected 0/0", up_state, up_tick); else passed++;
  endtask

  task automatic test_reset_midcount();
    pulse_start();
    cyc(4 * 37);
    total++; if (up_digits !== 8'h37) $display("FAIL mid_37: got %h expected 37", up_digits); else passed++;
    #2; resetn = 1'b0;
    #1;
    $display("async reset: state=%0d digits=%h tick=%b", up_state, up_digits, up_tick);
    total++; if ({up_state, up_digits, up_tick, up_roll, up_done} !== 13'd0) $display("FAIL async_reset: got %0d/%h/%b%b%b expected 0/00/000", up_state, up_digits, up_tick, up_roll, up_done); else passed++;
    @(negedge clock); resetn = 1'b1;
    cyc(3);
    total++; if ({up_state, up_tick} !== {2'd0, 1'b0}) $display("FAIL release_quiet: got %0d/%b expected 0/0", up_state, up_tick); else passed++;
    pulse_start();
    for (int k = 1; k < 4; k++) begin
      cyc(1);
      total++; if (up_tick !== 1'b0) $display("FAIL first_tick_early_%0d: got %b expected 0", k, up_tick); else passed++;
    end
    cyc(1);
    total++; if ({up_tick, up_digits} !== {1'b1, 8'h01}) $display("FAIL first_tick: got %b/%h expected 1/01", up_tick, up_digits); else passed++;
  endtask

  initial begin
    #1;
    test_reset();
    test_up_count();
    test_wrap();
    test_clamp();
    test_down();
    test_pause();
    test_clear_priority();
    test_reset_midcount();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule

// File: doc/game_timer.md
GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 Parameter DIV, default 1666667; clock cycles per count tick (50 MHz / 30 Hz); legal range 2..2^28.
REQ-002 Parameter NUM_DIGITS, default 4; number of BCD digits; legal range 1..8.
REQ-003 Parameter COUNT_DOWN, default 0; 0 = count up, 1 = count down from the preset.
REQ-004 Parameter WRAP, default 1; 1 = roll over at the terminal value, 0 = stop at the terminal value.
REQ-005 clock  input  1  system clock (CLOCK_50 domain); one clock; all state changes on its rising edge.
REQ-006 resetn  input  1  reset; asynchronous assertion, active-low.
REQ-007 start  input  1  level; begins counting from IDLE.
REQ-008 pause  input  1  single-cycle pulse; toggles between RUN and PAUSE.
REQ-009 clear  input  1  level; forces a return to IDLE.
REQ-010 preset  input  4*NUM_DIGITS  BCD load value; digit 0 is in bits [3:0].
REQ-011 digits  output  4*NUM_DIGITS  current BCD count; digit 0 (least significant) is in bits [3:0].
REQ-012 tick  output  1  one-cycle pulse on every prescaler terminal count while in RUN.
REQ-013 rollover  output  1  one-cycle pulse when the count wraps.
REQ-014 done  output  1  high while in DONE.
REQ-015 state  output  2  encoded FSM state.

Function
REQ-016 The prescaler shall count 0..DIV-1 in RUN only, hold its value in PAUSE, and clear to 0 in IDLE and DONE.
REQ-017 tick shall assert for exactly one cycle when the prescaler equals DIV-1, then the prescaler returns to 0.
REQ-018 digits shall update on the same edge that registers tick, so the new value is visible together with tick.
REQ-019 Up count: the digit chain shall be ripple-free BCD; a digit at 9 goes to 0 and carries into the next digit in the same cycle.
REQ-020 Down count: the digit chain shall be BCD; a digit at 0 goes to 9 and borrows from the next digit.
REQ-021 Up, WRAP=1: from all-9s the count goes to all-0s and rollover pulses; state stays RUN.
REQ-022 Up, WRAP=0: the count reaching all-9s enters DONE and digits hold.
REQ-023 Down: the count reaching all-0s enters DONE. With WRAP=1 it additionally pulses rollover and reloads preset on the next start.
REQ-024 FSM states: IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-025 IDLE: digits = 0 for up count or preset for down count, sampled continuously; start moves to RUN.
REQ-026 RUN: pause moves to PAUSE; the terminal condition moves to DONE.
REQ-027 PAUSE: pause moves back to RUN; digits and prescaler are frozen.
REQ-028 DONE: digits hold; start restarts from 0 or preset and moves to RUN.
REQ-029 Priority for simultaneous events shall be clear > start > pause > tick.
REQ-030 A tick coincident with pause shall be discarded, with no digit change.
REQ-031 Preset digits greater than 9 shall be clamped to 9 at load.

Reset
REQ-032 On resetn low, asynchronously: state=IDLE, prescaler=0, digits=0, tick=0, rollover=0, done=0.
REQ-033 A reset asserted mid-count shall abandon the count; no pulse shall be emitted on release.
REQ-034 After release, the first tick shall occur no earlier than DIV cycles after start.

Configuration
REQ-035 With GAME_TIMER_SEG_EN defined, an extra output seg of width 7*NUM_DIGITS shall present the active-low seven-segment code per digit (0=1000000 ... 9=0011000), registered one cycle after digits.
REQ-036 Without GAME_TIMER_SEG_EN, the seg port and its decode logic shall be absent; all other behaviour is identical.

Structure
REQ-037 Package game_timer_pkg shall hold the FSM state typedef, the BCD width constant (4), and the seven-segment code table.
REQ-038 Each digit shall be one instance of sub-module bcd_digit, generated NUM_DIGITS times.
REQ-039 bcd_digit shall take inc, dec, load and load_val inputs and produce value, carry and borrow outputs.

Verification
REQ-040 DIV=4, NUM_DIGITS=2, up count: start held 1 cycle -> tick every 4 cycles; digits 00,01..09,10 with carry on the 10th tick.
REQ-041 Up, WRAP=1, count at 99: next tick -> digits=00, rollover=1 for one cycle, state=RUN.
REQ-042 Down, preset=0x03: start -> digits 03,02,01,00, then done=1 and state=DONE; a further start reloads 03.
REQ-043 Pause at prescaler=2, hold 10 cycles, pause again -> next tick occurs exactly 2 cycles later; digits unchanged while paused.
REQ-044 Simultaneous clear+start+tick -> state=IDLE, digits=00, tick suppressed.
REQ-045 resetn pulsed low mid-count at digits=37 -> all outputs 0 immediately (asynchronous); no tick for DIV cycles after the next start.
